// File: rtl/pcie_link_sequencer.sv
// PCIe endpoint bring-up sequencer: holds PERST low for a programmed time,
// waits for a stable link-up indication and retries the reset/train cycle on
// timeout or link loss, giving up after a bounded number of retries.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE  (0) | waiting for start (or auto start), PERST asserted
// HOLD  (1) | PERST asserted, counting the hold time
// WAIT  (2) | PERST released, waiting for link_up
// STABLE(3) | link_up seen, counting consecutive high samples
// UP    (4) | link good
// FAIL  (5) | retries exhausted, waiting for start or force_reset
module pcie_link_sequencer #(
  parameter int PERST_HOLD_CYCLES = 500,
  parameter int LINKUP_TIMEOUT    = 65536,
  parameter int LINKUP_STABLE     = 16,
  parameter int MAX_RETRIES       = 3,
  parameter int AUTO_START        = 1,
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          start,
  input  logic          force_reset,
  input  logic          link_up,
  output logic          perst_n,
  output logic          busy,
  output logic          link_ok,
  output logic          fail,
  output logic [RW-1:0] retry_cnt,
  output logic [2:0]    state
);

  localparam int CMAX = (PERST_HOLD_CYCLES > LINKUP_TIMEOUT) ? PERST_HOLD_CYCLES : LINKUP_TIMEOUT;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int SW   = (LINKUP_STABLE > 1) ? $clog2(LINKUP_STABLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HOLD   = 3'd1,
    S_WAIT   = 3'd2,
    S_STABLE = 3'd3,
    S_UP     = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [SW-1:0]   r_stab;
  logic [RW-1:0]   r_retry;
  logic            r_perst_n;
  logic            r_busy;
  logic            r_link_ok;
  logic            r_fail;

  logic w_hold_done;
  logic w_timeout;
  logic w_stab_done;
  logic w_retry_max;
  logic w_force;

  assign w_hold_done = (r_cnt == CW'(PERST_HOLD_CYCLES - 1));
  assign w_timeout   = (r_cnt == CW'(LINKUP_TIMEOUT - 1));
  assign w_stab_done = link_up && (r_stab == SW'(LINKUP_STABLE - 1));
  assign w_retry_max = (r_retry == RW'(MAX_RETRIES));
  assign w_force     = force_reset && (r_state == S_HOLD || r_state == S_WAIT ||
                                       r_state == S_STABLE || r_state == S_UP);

  // Moves to a new state and updates the registered outputs on the same edge.
  task automatic go(input state_t s);
    r_state   <= s;
    r_perst_n <= (s == S_WAIT) || (s == S_STABLE) || (s == S_UP);
    r_busy    <= (s == S_HOLD) || (s == S_WAIT) || (s == S_STABLE);
    r_link_ok <= (s == S_UP);
    r_fail    <= (s == S_FAIL);
  endtask

  // Timeout handling shared by WAIT and STABLE.
  task automatic timeout_retry();
    r_cnt  <= '0;
    r_stab <= '0;
    if (w_retry_max) begin
      go(S_FAIL);
    end else begin
      r_retry <= r_retry + RW'(1);
      go(S_HOLD);
    end
  endtask

  // Sequencer FSM with counters and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_cnt   <= '0;
      r_stab  <= '0;
      r_retry <= '0;
      go(S_IDLE);
    end else if (w_force) begin
      r_cnt   <= '0;
      r_stab  <= '0;
      r_retry <= '0;
      go(S_HOLD);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start || (AUTO_START != 0)) begin
            r_cnt   <= '0;
            r_stab  <= '0;
            r_retry <= '0;
            go(S_HOLD);
          end
        end
        S_HOLD: begin
          if (w_hold_done) begin
            r_cnt <= '0;
            go(S_WAIT);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WAIT: begin
          if (link_up && (LINKUP_STABLE == 1)) begin
            r_cnt  <= '0;
            r_stab <= '0;
            go(S_UP);
          end else if (w_timeout) begin
            timeout_retry();
          end else if (link_up) begin
            r_stab <= SW'(1);
            go(S_STABLE);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STABLE: begin
          // Stability completing on the timeout edge still reaches UP.
          if (w_stab_done) begin
            r_cnt  <= '0;
            r_stab <= '0;
            go(S_UP);
          end else if (w_timeout) begin
            timeout_retry();
          end else begin
            r_cnt <= r_cnt + CW'(1);
            if (link_up) begin
              r_stab <= r_stab + SW'(1);
            end else begin
              r_stab <= '0;
              go(S_WAIT);
            end
          end
        end
        S_UP: begin
          // Link loss is a full retrain with a fresh retry budget.
          if (!link_up) begin
            r_cnt   <= '0;
            r_stab  <= '0;
            r_retry <= '0;
            go(S_HOLD);
          end
        end
        S_FAIL: begin
          if (start || force_reset) begin
            r_cnt   <= '0;
            r_stab  <= '0;
            r_retry <= '0;
            go(S_HOLD);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_stab  <= '0;
          r_retry <= '0;
          go(S_IDLE);
        end
      endcase
    end
  end

  assign perst_n   = r_perst_n;
  assign busy      = r_busy;
  assign link_ok   = r_link_ok;
  assign fail      = r_fail;
  assign retry_cnt = r_retry;
  assign state     = r_state;

endmodule
